// File: rtl/palette_lut_fade.sv
// Runtime-writable RGB palette: 2-cycle pipelined lookup scaled by a global fade level.
// Define PALETTE_TRANSPARENT_EN to add a transparent flag that blanks index 0.
module palette_lut_fade #(
    parameter int INDEX_W  = 5,
    parameter int CH_W     = 4,
    parameter int FADE_DIV = 1024
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 rd_valid,
    input  logic [INDEX_W-1:0]   rd_index,
    input  logic                 wr_en,
    input  logic [INDEX_W-1:0]   wr_index,
    input  logic [3*CH_W-1:0]    wr_rgb,
    output logic                 wr_ready,
    input  logic                 fade_start,
    input  logic                 fade_dir,
    output logic                 fade_busy,
    output logic                 out_valid,
    output logic [CH_W-1:0]      red,
    output logic [CH_W-1:0]      green,
    output logic [CH_W-1:0]      blue
`ifdef PALETTE_TRANSPARENT_EN
    ,
    output logic                 transparent
`endif
);

    localparam int DEPTH  = 2**INDEX_W;
    localparam int RGB_W  = 3*CH_W;
    localparam int LVL_W  = CH_W + 1;
    localparam int PROD_W = 2*CH_W + 1;
    localparam int DIV_W  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [LVL_W-1:0] FULL = {1'b1, {CH_W{1'b0}}};

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t               state_q, state_d;
    logic [INDEX_W-1:0]   ptr_q, ptr_d;
    logic                 mem_we;
    logic [INDEX_W-1:0]   mem_waddr;
    logic [RGB_W-1:0]     mem_wdat;
    logic [RGB_W-1:0]     mem_q [DEPTH];

    logic                 s1_vld_q, s1_vld_d;
    logic [RGB_W-1:0]     s1_rgb_q, s1_rgb_d;
    logic                 out_vld_q, out_vld_d;
    logic [CH_W-1:0]      red_q, red_d, green_q, green_d, blue_q, blue_d;
`ifdef PALETTE_TRANSPARENT_EN
    logic                 s1_zero_q, s1_zero_d;
    logic                 transp_q, transp_d;
`endif

    logic [LVL_W-1:0]     level_q, level_d;
    logic                 busy_q, busy_d;
    logic                 dir_q, dir_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [LVL_W-1:0]     target;

    function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c,
                                              input logic [LVL_W-1:0] lvl);
        return CH_W'((PROD_W'(c) * PROD_W'(lvl)) >> CH_W);
    endfunction

    // INIT sweeps every entry to zero; user writes are only taken in RUN.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        mem_we    = 1'b0;
        mem_waddr = wr_index;
        mem_wdat  = wr_rgb;
        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdat  = '0;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == '1) state_d = ST_RUN;
            end
            ST_RUN:  mem_we = wr_en;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdat;
    end

    always_comb begin
        s1_vld_d  = rd_valid;
        s1_rgb_d  = mem_q[rd_index];
`ifdef PALETTE_TRANSPARENT_EN
        s1_zero_d = (rd_index == '0);
        transp_d  = transp_q;
`endif
        out_vld_d = s1_vld_q;
        red_d     = red_q;
        green_d   = green_q;
        blue_d    = blue_q;
        if (s1_vld_q) begin
            red_d   = scale(s1_rgb_q[2*CH_W +: CH_W], level_q);
            green_d = scale(s1_rgb_q[CH_W +: CH_W], level_q);
            blue_d  = scale(s1_rgb_q[0 +: CH_W], level_q);
`ifdef PALETTE_TRANSPARENT_EN
            transp_d = s1_zero_q;
            if (s1_zero_q) begin
                red_d   = '0;
                green_d = '0;
                blue_d  = '0;
            end
`endif
        end
    end

    // A fade already at its target still raises busy for one cycle.
    always_comb begin
        level_d = level_q;
        busy_d  = busy_q;
        dir_d   = dir_q;
        div_d   = div_q;
        target  = dir_q ? FULL : '0;
        if (!busy_q) begin
            if (fade_start) begin
                dir_d  = fade_dir;
                div_d  = '0;
                busy_d = 1'b1;
            end
        end else if (level_q == target) begin
            busy_d = 1'b0;
        end else if (div_q == DIV_W'(FADE_DIV - 1)) begin
            div_d   = '0;
            level_d = dir_q ? level_q + 1'b1 : level_q - 1'b1;
            if (level_d == target) busy_d = 1'b0;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_INIT;
            ptr_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_rgb_q  <= '0;
            out_vld_q <= 1'b0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
`ifdef PALETTE_TRANSPARENT_EN
            s1_zero_q <= 1'b0;
            transp_q  <= 1'b0;
`endif
            level_q   <= FULL;
            busy_q    <= 1'b0;
            dir_q     <= 1'b0;
            div_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            s1_vld_q  <= s1_vld_d;
            s1_rgb_q  <= s1_rgb_d;
            out_vld_q <= out_vld_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
`ifdef PALETTE_TRANSPARENT_EN
            s1_zero_q <= s1_zero_d;
            transp_q  <= transp_d;
`endif
            level_q   <= level_d;
            busy_q    <= busy_d;
            dir_q     <= dir_d;
            div_q     <= div_d;
        end
    end

    assign wr_ready  = (state_q == ST_RUN);
    assign fade_busy = busy_q;
    assign out_valid = out_vld_q;
    assign red       = red_q;
    assign green     = green_q;
    assign blue      = blue_q;
`ifdef PALETTE_TRANSPARENT_EN
    assign transparent = transp_q;
`endif

endmodule

// File: tb/tb_palette_lut_fade.sv
// Scoreboard bench for palette_lut_fade: directed lookups/writes/fades, monitor checks every out_valid.
module tb_palette_lut_fade;
    localparam int INDEX_W  = 5;
    localparam int CH_W     = 4;
    localparam int FADE_DIV = 4;
`ifdef PALETTE_TRANSPARENT_EN
    localparam logic TR = 1'b1;
`else
    localparam logic TR = 1'b0;
`endif

    logic               Clk = 1'b0;
    logic               Reset_n = 1'b0;
    logic               rd_valid = 1'b0;
    logic [INDEX_W-1:0] rd_index = '0;
    logic               wr_en = 1'b0;
    logic [INDEX_W-1:0] wr_index = '0;
    logic [3*CH_W-1:0]  wr_rgb = '0;
    logic               wr_ready;
    logic               fade_start = 1'b0;
    logic               fade_dir = 1'b0;
    logic               fade_busy;
    logic               out_valid;
    logic [CH_W-1:0]    red, green, blue;
    logic               t_w;

    palette_lut_fade #(.INDEX_W(INDEX_W), .CH_W(CH_W), .FADE_DIV(FADE_DIV)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .rd_valid(rd_valid), .rd_index(rd_index),
        .wr_en(wr_en), .wr_index(wr_index), .wr_rgb(wr_rgb), .wr_ready(wr_ready),
        .fade_start(fade_start), .fade_dir(fade_dir), .fade_busy(fade_busy),
        .out_valid(out_valid), .red(red), .green(green), .blue(blue)
`ifdef PALETTE_TRANSPARENT_EN
        , .transparent(t_w)
`endif
    );
`ifndef PALETTE_TRANSPARENT_EN
    assign t_w = 1'b0;
`endif

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [12:0] exp_q[$];
    int          cyc_q[$];
    logic [12:0] mon_e;
    int          mon_c;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (Reset_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = cyc_q.pop_front();
                chk("lookup", {19'd0, t_w, red, green, blue}, {19'd0, mon_e});
                chk("latency", cyc - mon_c, 32'd2);
            end
        end
    end

    task automatic tick;
        @(negedge Clk);
        rd_valid   = 1'b0;
        wr_en      = 1'b0;
        fade_start = 1'b0;
    endtask

    task automatic rd(input int idx, input logic [12:0] e);
        rd_valid = 1'b1;
        rd_index = idx[INDEX_W-1:0];
        exp_q.push_back(e);
        cyc_q.push_back(cyc);
    endtask

    task automatic wr(input int idx, input logic [11:0] rgb);
        wr_en    = 1'b1;
        wr_index = idx[INDEX_W-1:0];
        wr_rgb   = rgb;
    endtask

    task automatic fade(input logic dir);
        fade_start = 1'b1;
        fade_dir   = dir;
    endtask

    initial begin
        repeat (3) tick;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rgb", {red, green, blue}, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_fade_busy", fade_busy, 0);
        #1 Reset_n = 1'b1;

        // INIT: 32 cycles, write to entry 2 at cycle 20 must be dropped
        for (int i = 1; i <= 32; i++) begin
            if (i >= 9) rd(7, 13'h0000);
            if (i == 20) wr(2, 12'hFFF);
            tick;
            chk("wr_ready_init", wr_ready, (i == 32) ? 1 : 0);
        end
        repeat (2) tick;

        wr(5, 12'hC2C); tick;
        rd(5, 13'h0C2C); tick;
        rd(0, {TR, 12'h000}); tick;
        rd(5, 13'h0C2C); tick;
        rd(2, 13'h0000); tick;

        // read-first collision
        wr(3, 12'h888); rd(3, 13'h0000); tick;
        rd(3, 13'h0888); tick;
        tick;
        tick;
        chk("hold_out_valid", out_valid, 0);
        chk("hold_rgb", {red, green, blue}, 12'h888);

        // fade in while already at full level
        wr(9, 12'hFFF); tick;
        fade(1'b1); tick;
        chk("pulse_busy_hi", fade_busy, 1);
        rd(9, 13'h0FFF); tick;
        chk("pulse_busy_lo", fade_busy, 0);
        rd(9, 13'h0FFF); tick;
        repeat (2) tick;

        // fade out; k counts edges since fade_start was sampled
        fade(1'b0); tick;
        for (int k = 0; k < 70; k++) begin
            if (k == 10) fade(1'b1);
            if (k >= 31 && k <= 33) rd(9, 13'h0777);
            if (k == 63) chk("fo_busy_63", fade_busy, 1);
            if (k == 64) chk("fo_busy_64", fade_busy, 0);
            tick;
        end
        rd(9, 13'h0000); tick;
        repeat (2) tick;

        // fade back in from black
        fade(1'b1); tick;
        for (int k = 0; k < 66; k++) begin
            if (k == 63) chk("fi_busy_63", fade_busy, 1);
            if (k == 64) chk("fi_busy_64", fade_busy, 0);
            tick;
        end
        rd(9, 13'h0FFF); tick;
        repeat (3) tick;

        // async reset in the middle of a fade-out
        fade(1'b0); tick;
        repeat (20) tick;
        #2 Reset_n = 1'b0;
        #1;
        chk("amid_out_valid", out_valid, 0);
        chk("amid_rgb", {red, green, blue}, 0);
        chk("amid_fade_busy", fade_busy, 0);
        chk("amid_wr_ready", wr_ready, 0);
        exp_q.delete();
        cyc_q.delete();
        repeat (2) tick;
        #1 Reset_n = 1'b1;
        repeat (32) tick;
        chk("post_rst_wr_ready", wr_ready, 1);
        wr(9, 12'hFFF); tick;
        rd(9, 13'h0FFF); tick;

        // index 0 handling (blanked only with the transparent option)
        wr(0, 12'hFFF); tick;
        wr(1, 12'h123); tick;
        rd(0, TR ? 13'h1000 : 13'h0FFF); tick;
        rd(1, 13'h0123); tick;
        repeat (4) tick;
        chk("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/palette_lut_fade.md
Name: palette_lut_fade

Overview:
- Writable, parametrised successor to the fixed background palette ROM in the sprite/background render path.
- Holds DEPTH entries of 3×CH_W-bit RGB, writable at runtime by the game/control logic.
- Serves one pipelined lookup per cycle to the VGA colour mapper.
- Includes a global brightness fade engine for screen fade-in/fade-out transitions.

Parameters:
- INDEX_W, 5, palette index width. DEPTH = 2**INDEX_W entries.
- CH_W, 4, bits per colour channel.
- FADE_DIV, 1024, clock cycles per brightness step. Must be ≥1.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- rd_valid  in  1  lookup request qualifier.
- rd_index  in  INDEX_W  palette index to look up.
- wr_en  in  1  palette entry write strobe.
- wr_index  in  INDEX_W  entry to write.
- wr_rgb  in  3*CH_W  {red, green, blue} write data.
- wr_ready  out  1  high when writes are accepted (not in INIT).
- fade_start  in  1  single-cycle pulse; starts a fade.
- fade_dir  in  1  direction, sampled with fade_start: 0 = fade out to black, 1 = fade in to full.
- fade_busy  out  1  high while a fade is running.
- out_valid  out  1  lookup result valid.
- red, green, blue  out  CH_W each  scaled lookup result.

Behaviour:
- Reset (async, Reset_n=0): out_valid=0, red/green/blue=0, fade_busy=0, wr_ready=0, level=2**CH_W (full), FSM → INIT with init pointer 0.
- Main FSM states:
  - INIT: writes 0 to entry[ptr] each cycle, ptr++. After entry DEPTH-1 is written, go to RUN the next cycle; takes DEPTH cycles. wr_ready=0; wr_en is ignored (write dropped). Lookups are still serviced and return the current (partly zeroed) contents, scaled.
  - RUN: wr_ready=1. A write with wr_en=1 updates the entry at the clock edge.
- Lookup pipeline, fixed 2-cycle latency, fully pipelined, no stalls:
  - Stage 1 registers the entry at rd_index.
  - Stage 2 registers each channel as (c × level) >> CH_W, where level is the value at stage-2 time. Product width is 2*CH_W+1; truncate after the shift. level = 2**CH_W must give the channel unchanged.
  - out_valid follows rd_valid delayed by 2 cycles.
  - red/green/blue hold their last value while out_valid=0.
- Read/write collision (same index, same cycle): read-first. The lookup returns the old entry; the new value is visible to lookups issued the next cycle or later.
- Fade engine:
  - level is CH_W+1 bits, range 0..2**CH_W.
  - fade_start while fade_busy=0: latch fade_dir, clear the divider counter, set fade_busy=1.
  - Every FADE_DIV cycles, step level by 1 toward the target (0 for out, 2**CH_W for in).
  - fade_busy drops in the cycle level reaches the target. If level already equals the target, fade_busy pulses for exactly one cycle and level is unchanged.
  - fade_start while fade_busy=1: ignored.
  - level persists between fades. Reset mid-fade restores full level.
- Fade and INIT are independent; both may run concurrently.

Optional Feature:
- Macro: PALETTE_TRANSPARENT_EN.
- Defined:
  - Adds output port transparent (1 bit, reset 0), pipelined alongside out_valid.
  - transparent=1 when the looked-up index was 0; colour outputs are forced to 0 for that lookup.
  - Entry 0 is still writable, but its colour is never output.
- Undefined: no port; index 0 behaves like any other entry.

Test Plan:
- Reset then INIT: release Reset_n, hold rd_valid=1 with rd_index=7 → wr_ready=0 for 32 cycles then 1. out_valid goes high 2 cycles after rd_valid. Outputs are 0 throughout.
- Write and lookup: in RUN, write index 5 = 12'hC2C, then read index 5 → red=C, green=2, blue=C exactly 2 cycles after the request at full level. Back-to-back reads of indices 5, 0, 5 → C2C, 000, C2C on consecutive cycles.
- Collision: write index 3 = 12'h888 while reading index 3 (old value 12'h000) in the same cycle → result 000. Repeat the read the next cycle → 888.
- Fade out (FADE_DIV=4 in bench): entry 12'hFFF, fade_start with fade_dir=0 → level steps 16→0 over 64 cycles. Mid-fade at level 8, output reads 7,7,7. fade_busy falls when level reaches 0 and output becomes 0. A second fade_start while busy does not restart the fade.
- Fade in at full level: fade_start with fade_dir=1 while level=16 → one-cycle fade_busy pulse, output unchanged. Async reset asserted mid-fade-out → level returns to 16, all outputs 0, FSM in INIT.
- With PALETTE_TRANSPARENT_EN: write entry 0 = 12'hFFF, read index 0 → transparent=1, rgb=000. Read index 1 → transparent=0.
